// File: rtl/core_dout_buf_if.sv
// Bus between the descrypt core, the result buffer and the draining arbiter.
// Optional dout_last signal exists only when CORE_DOUT_BUF_LAST_EN is defined.
interface core_dout_buf_if #(
   parameter int WIDTH = 4
);
   // Handshake: the core pushes one word per cycle and a header is only kept while
   // core_dout_ready=1. dout is valid while empty=0; it is consumed on a cycle with rd_en=1 and empty=0.
   logic [WIDTH-1:0] core_dout;
   logic             core_dout_ready;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             rd_en;
   logic             err_core_dout;
   logic [1:0]       dbg_wr_state;
`ifdef CORE_DOUT_BUF_LAST_EN
   logic             dout_last;

   modport master (
      output core_dout, rd_en,
      input  core_dout_ready, dout, empty, err_core_dout, dbg_wr_state, dout_last
   );
   modport slave (
      input  core_dout, rd_en,
      output core_dout_ready, dout, empty, err_core_dout, dbg_wr_state, dout_last
   );
`else
   modport master (
      output core_dout, rd_en,
      input  core_dout_ready, dout, empty, err_core_dout, dbg_wr_state
   );
   modport slave (
      input  core_dout, rd_en,
      output core_dout_ready, dout, empty, err_core_dout, dbg_wr_state
   );
`endif
endinterface

// File: rtl/core_dout_buf.sv
// Ring of N_PKT packet slots capturing short/long core result packets and replaying them per rd_en.
// Define CORE_DOUT_BUF_LAST_EN to drive dout_last (final word of the presented packet).
module core_dout_buf #(
   parameter int WIDTH     = 4,
   parameter int MAX_LEN   = 6,
   parameter int SHORT_LEN = 2,
   parameter int N_PKT     = 2
) (
   input logic            CLK,
   input logic            RESET_N,
   core_dout_buf_if.slave bus
);

   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int PTR_W = (N_PKT > 1) ? $clog2(N_PKT) : 1;
   localparam int CNT_W = $clog2(N_PKT + 1);

   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MAX_LEN - 1);
   localparam logic [IDX_W-1:0] SHORT_LAST = IDX_W'(SHORT_LEN - 1);
   localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(N_PKT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(N_PKT);

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_COLLECT = 2'd1,
      W_DISCARD = 2'd2
   } wr_state_e;

   wr_state_e        wr_state_q, wr_state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] mem_q [N_PKT][MAX_LEN];
   logic             long_q [N_PKT];

   logic             hdr, slot_free, pkt_end;
   logic             mem_we, flag_we, commit, err_set;
   logic             empty, rd_fire, release_pkt;
   logic [IDX_W-1:0] rd_last_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + 1'b1;
   endfunction

   assign hdr       = bus.core_dout[0];
   assign slot_free = (count_q < FULL_CNT);
   // Word 1 without EQUAL closes a short packet; otherwise the packet runs to MAX_LEN words.
   assign pkt_end   = ((wr_idx_q == SHORT_LAST) && !bus.core_dout[1]) || (wr_idx_q == LAST_IDX);

   // Write FSM: state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) wr_state_q <= W_IDLE;
      else          wr_state_q <= wr_state_d;
   end

   // Write FSM: next state
   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         W_IDLE:    if (hdr) wr_state_d = slot_free ? W_COLLECT : W_DISCARD;
         W_COLLECT,
         W_DISCARD: if (pkt_end) wr_state_d = W_IDLE;
         default:   wr_state_d = W_IDLE;
      endcase
   end

   // Write FSM: outputs
   always_comb begin
      mem_we   = 1'b0;
      flag_we  = 1'b0;
      commit   = 1'b0;
      err_set  = 1'b0;
      wr_idx_d = wr_idx_q;
      case (wr_state_q)
         W_IDLE: begin
            wr_idx_d = '0;
            if (hdr) begin
               wr_idx_d = IDX_W'(1);
               mem_we   = slot_free;
               err_set  = !slot_free;
            end
         end
         W_COLLECT, W_DISCARD: begin
            mem_we  = (wr_state_q == W_COLLECT);
            flag_we = (wr_state_q == W_COLLECT) && (wr_idx_q == SHORT_LAST);
            err_set = (wr_idx_q == SHORT_LAST) && (bus.core_dout[1:0] == 2'b00);
            commit  = (wr_state_q == W_COLLECT) && pkt_end;
            wr_idx_d = pkt_end ? '0 : wr_idx_q + 1'b1;
         end
         default: wr_idx_d = '0;
      endcase
   end

   // Read side
   always_comb begin
      rd_last_idx = long_q[rd_ptr_q] ? LAST_IDX : SHORT_LAST;
      empty       = (count_q == '0);
      rd_fire     = bus.rd_en && !empty;
      release_pkt = rd_fire && (rd_idx_q == rd_last_idx);
      rd_idx_d    = rd_idx_q;
      if (rd_fire) rd_idx_d = release_pkt ? '0 : rd_idx_q + 1'b1;
      rd_ptr_d = release_pkt ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      case ({commit, release_pkt})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      ready_d = (wr_state_d == W_IDLE) && (count_d < FULL_CNT);
      err_d   = err_q | err_set;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_idx_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         wr_idx_q <= wr_idx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   // Payload storage carries no reset; content is only observed once a slot is committed.
   always_ff @(posedge CLK) begin
      if (mem_we)  mem_q[wr_ptr_q][wr_idx_q] <= bus.core_dout;
      if (flag_we) long_q[wr_ptr_q]          <= bus.core_dout[1];
   end

   assign bus.core_dout_ready = ready_q;
   assign bus.empty           = empty;
   assign bus.dout            = mem_q[rd_ptr_q][rd_idx_q];
   assign bus.err_core_dout   = err_q;
   assign bus.dbg_wr_state    = wr_state_q;
`ifdef CORE_DOUT_BUF_LAST_EN
   assign bus.dout_last       = !empty && (rd_idx_q == rd_last_idx);
`endif

endmodule
